axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//  Shares the CPU's single AXI read channel between instruction fetch (IF) and data read (MEM).
//  Sequences one outstanding AR/R transaction at a time and tags each transaction by source on arid/rid.
//  Buffers each response until its requester accepts it, and discards IF responses invalidated by flush.
//  Sits between if_pc/if_id, the MEM stage and the AXI master port.
// PARAMETERS
//  STARVE_LIMIT  8      consecutive cycles an IF request may lose to MEM before IF is forced to win
//  ID_IF         4'd0   arid tag for IF transactions
//  ID_MEM        4'd1   arid tag for MEM transactions
// PORTS
//  clk          in   1   clock; rising edge
//  reset        in   1   asynchronous, active-low reset
//  if_req       in   1   IF read request valid
//  if_addr      in   32  IF virtual address; held while if_req=1 && if_gnt=0
//  if_gnt       out  1   IF request accepted this cycle (pulse)
//  if_rvalid    out  1   IF data valid; held until if_rready
//  if_rready    in   1   IF consumer ready
//  if_rdata     out  32  fetched instruction
//  mem_req      in   1   MEM read request valid
//  mem_addr     in   32  MEM virtual address; held until mem_gnt
//  mem_gnt      out  1   MEM request accepted (pulse)
//  mem_rvalid   out  1   MEM data valid; held until mem_rready
//  mem_rready   in   1   MEM consumer ready
//  mem_rdata    out  32  loaded word
//  flush        in   1   pipeline flush; kills the IF transaction in flight
//  rd_err       out  1   qualifies if_rvalid/mem_rvalid: rresp != OKAY
//  arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR channel
//  arready      in   1   AXI AR ready
//  rid/rdata/rresp/rlast/rvalid  in  AXI R channel
//  rready       out  1   AXI R ready
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; every output 0; starve counter 0; drop flag 0.
//  - Constant AR fields: arlen=0, arsize=3'b010, arburst=0, arlock=0, arcache=0, arprot=3'b001.
//  - araddr mapping: if addr[31:29] is 3'b100 or 3'b101, araddr = {3'b0, addr[28:0]}; otherwise araddr = addr unchanged.
//  - FSM:
//    - IDLE -> ADDR on any request.
//      - Grant goes to MEM if mem_req, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
//      - The winner's gnt pulses in that cycle; its address, arid and source are latched.
//      - flush=1 in IDLE suppresses if_gnt.
//    - ADDR: arvalid=1 with araddr/arid stable. On arvalid && arready, arvalid drops next cycle -> DATA.
//    - DATA: rready=1. On rvalid:
//      - Latch rdata and rresp -> RESP.
//      - rid != latched arid: same transfer, and rd_err is forced to 1.
//    - RESP: raise the owner's *_rvalid. On *_rready -> IDLE. The next grant is possible one cycle later.
//  - Latency: req -> gnt same cycle; gnt -> arvalid next cycle; minimum req-to-rvalid is 3 cycles with 0-wait AXI.
//  - Starve counter: increments per cycle where if_req=1 but MEM was granted or the channel is busy; clears on if_gnt.
//    Saturates at STARVE_LIMIT.
//  - Flush:
//    - flush=1 with the current owner IF in ADDR/DATA sets drop.
//      - The AR handshake still completes (arvalid never retracted).
//      - R is still accepted.
//      - On R arrival the arbiter returns directly to IDLE; if_rvalid is never raised.
//    - flush=1 in RESP with owner IF clears if_rvalid and returns to IDLE the next cycle.
//    - flush never affects a MEM transaction.
//    - drop clears on entry to IDLE.
//  - Simultaneous: if_req && mem_req in IDLE -> MEM wins (below starve limit). Flush and if_req in the same cycle -> no if_gnt.
//  - Only one of if_rvalid/mem_rvalid is ever 1. rvalid/rdata are stable until their ready.
//  - rlast is ignored (single beat). Reset mid-transaction abandons it; the AXI slave is reset alongside.
// STRUCTURE
//  - State encodings (IDLE/ADDR/DATA/RESP) and RstEnable/Valid/Ready macros go in defines.v.
//  - One sub-module, axi_kseg_map: combinational virtual->physical address mapping, reused by the write adapter.
// TESTING
//  1. if_req=1, if_addr=0xBFC00000, 0-wait slave with rdata=0x3C1D0001 -> araddr=0x1FC00000, arid=0; if_rvalid on cycle 3; mem_rvalid never 1.
//  2. if_req and mem_req (0x80001000) in the same cycle -> mem_gnt first, arid=1, araddr=0x00001000; IF is served next.
//  3. mem_req held constantly with if_req=1 -> if_gnt after exactly STARVE_LIMIT=8 MEM-won/busy cycles.
//  4. flush one cycle after if_gnt, rvalid delayed 5 cycles -> AR completes, rready=1, if_rvalid stays 0, back to IDLE.
//  5. if_rready=0 for 4 cycles in RESP -> if_rdata/if_rvalid stable, arvalid stays 0; rresp=2'b10 -> rd_err=1.
//  6. reset=0 asserted asynchronously mid-DATA -> all outputs 0 immediately; first request after release behaves as in 1.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared types and constant AR fields for the read arbiter
package axi_read_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;
  typedef enum logic {SRC_IF, SRC_MEM} src_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [7:0] AR_LEN    = 8'd0;
  localparam logic [2:0] AR_SIZE   = 3'b010;
  localparam logic [1:0] AR_BURST  = 2'b00;
  localparam logic [1:0] AR_LOCK   = 2'b00;
  localparam logic [3:0] AR_CACHE  = 4'b0000;
  localparam logic [2:0] AR_PROT   = 3'b001;
endpackage

// File: rtl/axi_kseg_map.sv
// axi_kseg_map: folds the kseg0/kseg1 windows onto physical low memory
module axi_kseg_map (
  input  logic [31:0] vaddr,
  output logic [31:0] paddr
);
  always_comb paddr = (vaddr[31:29] == 3'b100 || vaddr[31:29] == 3'b101) ? {3'b000, vaddr[28:0]} : vaddr;
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel between IF and MEM, one transaction in flight
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int         STARVE_LIMIT = 8,
  parameter logic [3:0] ID_IF        = 4'd0,
  parameter logic [3:0] ID_MEM       = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  input  logic        if_rready,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  input  logic        mem_rready,
  output logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        rd_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_e        state_q, state_d;
  src_e          owner_q, owner_d;
  logic [3:0]    arid_q, arid_d;
  logic [31:0]   addr_q, addr_d, rdata_q, rdata_d, sel_vaddr, sel_paddr;
  logic          err_q, err_d, drop_q, drop_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          idle, at_limit, if_win, mem_win, if_flush;
  logic          unused;
  assign unused = rlast;
  axi_kseg_map u_map (.vaddr(sel_vaddr), .paddr(sel_paddr));
  always_comb begin
    idle      = reset && state_q == IDLE;
    at_limit  = starve_q == SW'(STARVE_LIMIT);
    if_win    = idle && if_req && !flush && (!mem_req || at_limit);
    mem_win   = idle && mem_req && !if_win;
    if_flush  = flush && owner_q == SRC_IF;
    sel_vaddr = if_win ? if_addr : mem_addr;
    state_d   = state_q;
    owner_d   = owner_q;
    arid_d    = arid_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    drop_d    = drop_q;
    case (state_q)
      IDLE: if (if_win || mem_win) begin
        state_d = ADDR;
        owner_d = if_win ? SRC_IF : SRC_MEM;
        arid_d  = if_win ? ID_IF : ID_MEM;
        addr_d  = sel_paddr;
      end
      ADDR: begin
        drop_d  = drop_q || if_flush;
        state_d = arready ? DATA : ADDR;
      end
      DATA: begin
        drop_d = drop_q || if_flush;
        if (rvalid) begin
          state_d = drop_d ? IDLE : RESP;
          rdata_d = rdata;
          err_d   = rresp != RESP_OKAY || rid != arid_q;
        end
      end
      RESP: if (if_flush || (owner_q == SRC_IF ? if_rready : mem_rready)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) drop_d = 1'b0;
    starve_d = if_win ? '0 : (if_req && (mem_win || state_q != IDLE) && !at_limit) ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= SRC_IF;
      arid_q   <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      arid_q   <= arid_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      starve_q <= starve_d;
    end
  assign if_gnt     = if_win;
  assign mem_gnt    = mem_win;
  assign arvalid    = state_q == ADDR;
  assign araddr     = addr_q;
  assign arid       = arid_q;
  assign rready     = state_q == DATA;
  assign if_rvalid  = state_q == RESP && owner_q == SRC_IF;
  assign mem_rvalid = state_q == RESP && owner_q == SRC_MEM;
  assign rd_err     = state_q == RESP && err_q;
  assign if_rdata   = rdata_q;
  assign mem_rdata  = rdata_q;
  assign arlen      = AR_LEN;
  assign arsize     = AR_SIZE;
  assign arburst    = AR_BURST;
  assign arlock     = AR_LOCK;
  assign arcache    = AR_CACHE;
  assign arprot     = AR_PROT;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed stimulus with AR/R scoreboards checked by a negedge monitor
module tb_axi_read_arbiter;
  logic clk = 0, reset = 0;
  logic if_req = 0, if_rready = 1, mem_req = 0, mem_rready = 1, flush = 0;
  logic [31:0] if_addr = 0, mem_addr = 0;
  logic if_gnt, if_rvalid, mem_gnt, mem_rvalid, rd_err;
  logic [31:0] if_rdata, mem_rdata;
  logic [3:0] arid, arcache;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  logic arvalid, rready;
  logic arready = 1;
  logic [3:0] rid = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0;
  logic rlast = 0, rvalid = 0;
  int total = 0, bad = 0;
  localparam logic [31:0] KEY = 32'h23DD0001;
  int rdly = 0;
  logic [1:0] resp_cfg = 0;
  bit rid_bad = 0;
  typedef struct {logic [31:0] addr; logic [3:0] id;} ar_t;
  typedef struct {bit mem; logic [31:0] data; bit err;} r_t;
  ar_t ar_q[$];
  r_t  r_q[$];
  ar_t ea;
  r_t  er;
  always #5 clk = ~clk;
  axi_read_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rready(if_rready), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .flush(flush), .rd_err(rd_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // AXI slave: data = araddr ^ KEY, returned rdly cycles after the AR handshake
  int cnt = 0;
  bit pend = 0;
  logic [3:0] lid = 0;
  logic [31:0] laddr = 0;
  always @(posedge clk or negedge reset)
    if (!reset) begin
      pend <= 0;
      rvalid <= 0;
      rlast <= 0;
    end else begin
      if (rvalid && rready) begin
        rvalid <= 0;
        rlast <= 0;
      end
      if (arvalid && arready) begin
        lid <= arid;
        laddr <= araddr;
        if (rdly == 0) begin
          rvalid <= 1; rlast <= 1; rid <= rid_bad ? arid ^ 4'd1 : arid; rdata <= araddr ^ KEY; rresp <= resp_cfg;
        end else begin
          pend <= 1; cnt <= rdly - 1;
        end
      end else if (pend) begin
        if (cnt == 0) begin
          pend <= 0; rvalid <= 1; rlast <= 1; rid <= rid_bad ? lid ^ 4'd1 : lid; rdata <= laddr ^ KEY; rresp <= resp_cfg;
        end else cnt <= cnt - 1;
      end
    end
  always @(negedge clk)
    if (reset) begin
      if (arvalid && arready) begin
        if (ar_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got addr %h id %0d want no AR", araddr, arid);
        end else begin
          ea = ar_q.pop_front();
          chk("ar_addr", araddr, ea.addr);
          chk("ar_id", {28'd0, arid}, {28'd0, ea.id});
          chk("ar_const", {10'd0, arlen, arsize, arburst, arlock, arcache, arprot}, {10'd0, 8'd0, 3'b010, 2'd0, 2'd0, 4'd0, 3'b001});
        end
      end
      if (if_rvalid || mem_rvalid) begin
        chk("rvalid_onehot", {31'd0, if_rvalid && mem_rvalid}, 32'd0);
        if ((if_rvalid && if_rready) || (mem_rvalid && mem_rready)) begin
          if (r_q.size() == 0) begin
            total++; bad++;
            $display("FAIL r_unexpected: got if_rvalid=%0d mem_rvalid=%0d want none", if_rvalid, mem_rvalid);
          end else begin
            er = r_q.pop_front();
            chk("r_src", {31'd0, mem_rvalid}, {31'd0, er.mem});
            chk("r_data", mem_rvalid ? mem_rdata : if_rdata, er.data);
            chk("r_err", {31'd0, rd_err}, {31'd0, er.err});
          end
        end
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_ar(input logic [31:0] a, input logic [3:0] id);
    ar_q.push_back('{a, id});
  endtask
  task automatic exp_r(input bit mem, input logic [31:0] d, input bit e);
    r_q.push_back('{mem, d, e});
  endtask
  task automatic wait_gnt(input bit mem, output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (mem ? mem_gnt : if_gnt) break;
      waited++;
      if (waited > 200) begin
        total++; bad++;
        $display("FAIL gnt_timeout: got no %s gnt want gnt", mem ? "mem" : "if");
        break;
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((r_q.size() != 0 || ar_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (r_q.size() != 0 || ar_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d ar %0d r pending want 0", ar_q.size(), r_q.size());
    end
    step();
    step();
  endtask
  task automatic wait_if_rvalid(output int n);
    n = 0;
    while (!if_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int w, n, lost;
    bit seen;
    if_req = 1; mem_req = 1; if_addr = 32'h100; mem_addr = 32'h200;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_gnt", {31'd0, if_gnt}, 0);
    chk("rst_mem_gnt", {31'd0, mem_gnt}, 0);
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_rready", {31'd0, rready}, 0);
    chk("rst_rvalids", {30'd0, if_rvalid, mem_rvalid}, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_rd_err", {31'd0, rd_err}, 0);
    if_req = 0; mem_req = 0;
    step();
    reset = 1;
    step();
    // T1: kseg1 fetch, 3-cycle latency
    exp_ar(32'h1FC00000, 4'd0);
    exp_r(0, 32'h3C1D0001, 0);
    if_req = 1; if_addr = 32'hBFC00000;
    wait_gnt(0, w);
    chk("t1_gnt_same_cycle", w, 0);
    step(); if_req = 0;
    wait_if_rvalid(n);
    chk("t1_latency", n, 3);
    drain();
    // T2: simultaneous request, MEM first
    exp_ar(32'h00001000, 4'd1); exp_r(1, 32'h23DD1001, 0);
    exp_ar(32'h00400000, 4'd0); exp_r(0, 32'h239D0001, 0);
    if_req = 1; if_addr = 32'h00400000; mem_req = 1; mem_addr = 32'h80001000;
    wait_gnt(1, w);
    chk("t2_mem_wait", w, 0);
    chk("t2_no_if_gnt", {31'd0, if_gnt}, 0);
    step(); mem_req = 0;
    wait_gnt(0, w);
    step(); if_req = 0;
    drain();
    // T3: starvation limit
    exp_ar(32'h00002000, 4'd1); exp_r(1, 32'h23DD2001, 0);
    exp_ar(32'h00002000, 4'd1); exp_r(1, 32'h23DD2001, 0);
    exp_ar(32'h00003000, 4'd0); exp_r(0, 32'h23DD3001, 0);
    mem_req = 1; mem_addr = 32'h00002000; if_req = 1; if_addr = 32'h00003000;
    lost = 0;
    forever begin
      @(negedge clk);
      if (if_gnt || lost > 100) break;
      lost++;
    end
    chk("t3_starve_cycles", lost, 8);
    step(); if_req = 0; mem_req = 0;
    drain();
    // T4: flush blocks grant, then flush kills an in-flight fetch
    flush = 1; if_req = 1; if_addr = 32'h9FC00100;
    @(negedge clk);
    chk("t4_flush_blocks_gnt", {31'd0, if_gnt}, 0);
    step(); flush = 0; rdly = 5;
    exp_ar(32'h1FC00100, 4'd0);
    wait_gnt(0, w);
    chk("t4_gnt_after_flush", w, 0);
    step(); if_req = 0; flush = 1;
    step(); flush = 0;
    seen = 0; n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      if (rvalid && rready) seen = 1;
    end
    chk("t4_r_accepted", {31'd0, seen}, 1);
    @(negedge clk);
    chk("t4_no_if_rvalid", {31'd0, if_rvalid}, 0);
    chk("t4_rready_low", {31'd0, rready}, 0);
    step(); rdly = 0;
    exp_ar(32'h00000010, 4'd1); exp_r(1, 32'h23DD0011, 0);
    mem_req = 1; mem_addr = 32'hA0000010;
    wait_gnt(1, w);
    chk("t4_idle_after_drop", w, 0);
    step(); mem_req = 0;
    drain();
    // T5: backpressure in RESP with SLVERR
    resp_cfg = 2'b10; if_rready = 0;
    exp_ar(32'h00400040, 4'd0); exp_r(0, 32'h239D0041, 1);
    if_req = 1; if_addr = 32'h00400040;
    wait_gnt(0, w);
    step(); if_req = 0;
    wait_if_rvalid(n);
    chk("t5_rvalid_seen", {31'd0, if_rvalid}, 1);
    step();
    exp_ar(32'hC0000200, 4'd1); exp_r(1, 32'hE3DD0201, 0);
    mem_req = 1; mem_addr = 32'hC0000200;
    repeat (4) begin
      @(negedge clk);
      chk("t5_hold_valid", {31'd0, if_rvalid}, 1);
      chk("t5_hold_data", if_rdata, 32'h239D0041);
      chk("t5_arvalid_low", {31'd0, arvalid}, 0);
      chk("t5_mem_gnt_low", {31'd0, mem_gnt}, 0);
      chk("t5_rd_err", {31'd0, rd_err}, 1);
    end
    step(); if_rready = 1; resp_cfg = 0;
    wait_gnt(1, w);
    step(); mem_req = 0;
    drain();
    // T5b: flush while IF response waits in RESP
    if_rready = 0;
    exp_ar(32'h00000300, 4'd0);
    if_req = 1; if_addr = 32'h00000300;
    wait_gnt(0, w);
    step(); if_req = 0;
    wait_if_rvalid(n);
    chk("t5b_rvalid_seen", {31'd0, if_rvalid}, 1);
    step(); flush = 1;
    step(); flush = 0; if_rready = 1;
    repeat (2) begin
      @(negedge clk);
      chk("t5b_flushed_rvalid", {31'd0, if_rvalid}, 0);
    end
    drain();
    // T7: rid mismatch forces rd_err
    rid_bad = 1;
    exp_ar(32'h00000400, 4'd1); exp_r(1, 32'h23DD0401, 1);
    mem_req = 1; mem_addr = 32'h00000400;
    wait_gnt(1, w);
    step(); mem_req = 0;
    drain();
    rid_bad = 0;
    // T6: async reset mid-DATA, then a clean fetch
    rdly = 5;
    exp_ar(32'h00000500, 4'd0);
    if_req = 1; if_addr = 32'h00000500;
    wait_gnt(0, w);
    step(); if_req = 0;
    n = 0;
    while (!rready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_data", {31'd0, rready}, 1);
    #2;
    if_req = 1; mem_req = 1; reset = 0;
    #1;
    chk("t6_ctl_zero", {24'd0, arvalid, rready, if_gnt, mem_gnt, if_rvalid, mem_rvalid, rd_err, 1'b0}, 0);
    chk("t6_araddr_zero", araddr, 0);
    chk("t6_arid_zero", {28'd0, arid}, 0);
    chk("t6_rdata_zero", if_rdata | mem_rdata, 0);
    if_req = 0; mem_req = 0; rdly = 0;
    step();
    reset = 1;
    step();
    exp_ar(32'h1FC00000, 4'd0);
    exp_r(0, 32'h3C1D0001, 0);
    if_req = 1; if_addr = 32'hBFC00000;
    wait_gnt(0, w);
    chk("t6_gnt_same_cycle", w, 0);
    step(); if_req = 0;
    wait_if_rvalid(n);
    chk("t6_latency", n, 3);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
